// File: rtl/shift_unit_seq.sv
// shift_unit_seq: multi-cycle SRL/SLL/SRA/ROR shifter, one barrel stage per clock
module shift_unit_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rt,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [1:0] M_SRL = 2'b00, M_SLL = 2'b01, M_SRA = 2'b10;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, rd_q, rd_d, sra_v, shifted, stage;
  logic [SHW-1:0]   sh_q, sh_d, k_q, k_d;
  logic [1:0]       md_q, md_d;
  logic [SHW:0]     amt, ramt;
  assign in_ready  = (state_q == IDLE) & ~reset;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign rd        = rd_q;
  // SRA kept in its own assignment so the signed shift is not turned logical by unsigned ternary operands
  always_comb begin
    amt     = (SHW+1)'(1) << k_q;
    ramt    = (SHW+1)'(WIDTH) - amt;
    sra_v   = $signed(acc_q) >>> amt;
    shifted = md_q == M_SRL ? acc_q >> amt :
              md_q == M_SLL ? acc_q << amt :
              md_q == M_SRA ? sra_v : (acc_q >> amt) | (acc_q << ramt);
    stage   = sh_q[k_q] ? shifted : acc_q;
  end
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    md_d    = md_q;
    k_d     = k_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: if (in_valid) begin
        acc_d   = rt;
        sh_d    = shamt;
        md_d    = mode;
        k_d     = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        acc_d = stage;
        k_d   = k_q + 1'b1;
        if (k_q == SHW'(SHW-1)) begin
          rd_d    = stage;
          k_d     = '0;
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sh_q    <= '0;
      md_q    <= '0;
      k_q     <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      md_q    <= md_d;
      k_q     <= k_d;
      rd_q    <= rd_d;
    end
  end
endmodule

// File: tb/tb_shift_unit_seq.sv
// tb_shift_unit_seq: directed and random checks of 32-bit and 8-bit shift_unit_seq against an arithmetic model
module tb_shift_unit_seq;
  logic clk = 0, reset = 1;
  logic iv32 = 0, or32 = 0, ir32, ov32, bz32;
  logic [31:0] rt32 = 0, rd32;
  logic [4:0] sh32 = 0;
  logic [1:0] md32 = 0;
  logic iv8 = 0, or8 = 0, ir8, ov8, bz8;
  logic [7:0] rt8 = 0, rd8;
  logic [2:0] sh8 = 0;
  logic [1:0] md8 = 0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  shift_unit_seq dut32 (.clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32), .rt(rt32),
    .shamt(sh32), .mode(md32), .out_valid(ov32), .out_ready(or32), .rd(rd32), .busy(bz32));
  shift_unit_seq #(.WIDTH(8), .SHW(3)) dut8 (.clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
    .rt(rt8), .shamt(sh8), .mode(md8), .out_valid(ov8), .out_ready(or8), .rd(rd8), .busy(bz8));

  function automatic logic [31:0] model(input int w, input logic [1:0] m, input logic [31:0] r, input int s);
    logic [63:0] mask, v, res;
    mask = (64'd1 << w) - 1;
    v = {32'd0, r} & mask;
    case (m)
      2'b00: res = v >> s;
      2'b01: res = (v << s) & mask;
      2'b10: res = (v >> s) | (v[w-1] ? (mask & ~(mask >> s)) : 64'd0);
      default: res = ((v >> s) | (v << (w - s))) & mask;
    endcase
    return res[31:0];
  endfunction

  function automatic logic [31:0] o_rd(input int w);  return w == 32 ? rd32 : {24'd0, rd8}; endfunction
  function automatic logic o_ov(input int w);  return w == 32 ? ov32 : ov8; endfunction
  function automatic logic o_ir(input int w);  return w == 32 ? ir32 : ir8; endfunction
  function automatic logic o_bz(input int w);  return w == 32 ? bz32 : bz8; endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic v, input logic [1:0] m, input logic [31:0] r, input int s);
    if (w == 32) begin iv32 = v; md32 = m; rt32 = r; sh32 = 5'(s); end
    else begin iv8 = v; md8 = m; rt8 = r[7:0]; sh8 = 3'(s); end
  endtask

  task automatic set_ordy(input int w, input logic v);
    if (w == 32) or32 = v; else or8 = v;
  endtask

  task automatic run(input int w, input logic [1:0] m, input logic [31:0] r, input int s,
                     input int hold, input string tag);
    logic [31:0] exp;
    int cyc;
    exp = model(w, m, r, s);
    cyc = 0;
    while (!o_ir(w) && cyc < 20) begin step(); cyc++; end
    chk({tag, "_inrdy"}, 32'(o_ir(w)), 1);
    drive(w, 1, m, r, s);
    step();
    drive(w, 0, 2'($urandom), $urandom, int'($urandom_range(w - 1)));
    chk({tag, "_busy"}, 32'(o_bz(w)), 1);
    cyc = 0;
    while (!o_ov(w) && cyc < 20) begin step(); cyc++; end
    chk({tag, "_lat"}, cyc, w == 32 ? 5 : 3);
    chk({tag, "_rd"}, o_rd(w), exp);
    for (int i = 0; i < hold; i++) begin
      drive(w, 1, 2'($urandom), $urandom, int'($urandom_range(w - 1)));
      step();
      chk({tag, "_hold_ov"}, 32'(o_ov(w)), 1);
      chk({tag, "_hold_rd"}, o_rd(w), exp);
      chk({tag, "_hold_irdy"}, 32'(o_ir(w)), 0);
    end
    set_ordy(w, 1);
    step();
    drive(w, 0, 0, 0, 0);
    set_ordy(w, 0);
    chk({tag, "_post_ov"}, 32'(o_ov(w)), 0);
    chk({tag, "_post_irdy"}, 32'(o_ir(w)), 1);
    chk({tag, "_post_busy"}, 32'(o_bz(w)), 0);
    chk({tag, "_post_rd"}, o_rd(w), exp);
    step();
    chk({tag, "_idle_ov"}, 32'(o_ov(w)), 0);
  endtask

  initial begin
    step();
    step();
    chk("rst_rd", rd32, 0);
    chk("rst_ov", 32'(ov32), 0);
    chk("rst_busy", 32'(bz32), 0);
    chk("rst_irdy", 32'(ir32), 0);
    reset = 0;
    #1;
    chk("rst_rel_irdy", 32'(ir32), 1);
    chk("tp1_srl1", model(32, 2'b00, 32'hFFFFFFFF, 1), 32'h7FFFFFFF);
    run(32, 2'b00, 32'hFFFFFFFF, 1, 0, "srl1");
    run(32, 2'b00, 32'hFFFFFFFF, 3, 0, "srl3");
    run(32, 2'b00, 32'hFFFFFFFF, 31, 0, "srl31");
    chk("tp2_sra", model(32, 2'b10, 32'h80000000, 4), 32'hF8000000);
    run(32, 2'b10, 32'h80000000, 4, 0, "sra4");
    run(32, 2'b01, 32'h00000001, 31, 0, "sll31");
    run(32, 2'b11, 32'h00000001, 1, 0, "ror1");
    run(32, 2'b10, 32'h7FFFFFF0, 4, 0, "sra4p");
    for (int m = 0; m < 4; m++) run(32, 2'(m), 32'hA5A5A5A5, 0, 0, "zero");
    run(32, 2'b11, 32'h12345678, 8, 3, "bp");
    drive(32, 1, 2'b01, 1, 7);
    step();
    drive(32, 0, 0, 0, 0);
    step();
    reset = 1;
    step();
    chk("midrst_rd", rd32, 0);
    chk("midrst_ov", 32'(ov32), 0);
    chk("midrst_busy", 32'(bz32), 0);
    chk("midrst_irdy", 32'(ir32), 0);
    reset = 0;
    step();
    chk("midrst_rel_irdy", 32'(ir32), 1);
    chk("midrst_rel_ov", 32'(ov32), 0);
    chk("tp5_sll7", model(32, 2'b01, 1, 7), 32'h00000080);
    run(32, 2'b01, 32'h00000001, 7, 0, "sll7");
    chk("tp6_ror8", model(8, 2'b11, 32'h81, 3), 32'h30);
    chk("tp6_sra8", model(8, 2'b10, 32'h90, 7), 32'hFF);
    run(8, 2'b11, 32'h81, 3, 0, "w8_ror3");
    run(8, 2'b10, 32'h90, 7, 0, "w8_sra7");
    run(8, 2'b01, 32'h5A, 5, 2, "w8_bp");
    for (int i = 0; i < 40; i++)
      run(32, 2'($urandom), $urandom, int'($urandom_range(31)), int'($urandom_range(2)), "rnd32");
    for (int i = 0; i < 20; i++)
      run(8, 2'($urandom), $urandom, int'($urandom_range(7)), int'($urandom_range(1)), "rnd8");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
